cbx_param_dbuf: RTL and testbench

- Parametrised X-channel connection block, successor to the fixed 9-track / 4-pin / 6-input generation.
- Channel width, pin count, mux size and track stride are generic.
- Configuration is double-buffered: a shadow shift chain is committed atomically to an active select register, with shift counting, commit handshake and error reporting.
- Sits between the X routing channel and the bottom I/O grid pins, on the prog_clk configuration chain.

---
 rtl/cbx_param_dbuf_pkg.sv | 35 +++
 rtl/cbx_param_dbuf_ipin_mux.sv | 26 ++
 rtl/cbx_param_dbuf.sv | 130 +++++++++++++
 tb/tb_cbx_param_dbuf.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbx_param_dbuf_pkg.sv
// cb_pkg: shared helpers for the parametrised X-channel connection block.
//   cb_clog2       - constant ceil(log2(v)), 0 for v <= 1
//   cb_track_idx   - channel track feeding mux input pair k of pin i
//   cb_mux_size_ok - legality of MUX_SIZE against CHAN_W
//   cb_sel_w_ok    - legality of the derived select width
package cb_pkg;

  function automatic int cb_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    for (int n = 0; n < 32; n++) begin
      if (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

  function automatic int cb_track_idx(input int i, input int k,
                                      input int stride, input int chan_w);
    return (i + k * stride) % chan_w;
  endfunction

  function automatic bit cb_mux_size_ok(input int mux_size, input int chan_w);
    return ((mux_size % 2) == 0) && (mux_size >= 2) && (mux_size <= 2 * chan_w);
  endfunction

  function automatic bit cb_sel_w_ok(input int sel_w);
    return sel_w >= 1;
  endfunction

endpackage

// File: rtl/cbx_param_dbuf_ipin_mux.sv
// cb_ipin_mux: one grid-pin input mux with an output gate.
//   i_in  [MUX_SIZE-1:0] - mux candidates (even = left track, odd = right track)
//   i_sel [SEL_W-1:0]    - select; values >= MUX_SIZE drive 0
//   i_en                 - gate; pin is held at 0 while low
//   o_out                - selected pin value (combinational)
module cb_ipin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = 3
) (
  input  logic [MUX_SIZE-1:0] i_in,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_en,
  output logic                o_out
);

  // Explicit compare per input so out-of-range selects fall through to 0.
  always_comb begin
    o_out = 1'b0;
    for (int j = 0; j < MUX_SIZE; j++) begin
      if (i_en && (i_sel == SEL_W'(j))) begin
        o_out = i_in[j];
      end
    end
  end

endmodule

// File: rtl/cbx_param_dbuf.sv
// cbx_param_dbuf: parametrised X-channel connection block with a
// double-buffered configuration chain.
//   prog_clk, prog_reset        - config clock, synchronous active-high reset
//   chanx_left_in/right_in      - channel tracks in
//   chanx_left_out/right_out    - pass-through of the opposite side
//   ipin_out                    - grid pin outputs (gated until first commit)
//   ccff_en, ccff_head          - shadow chain shift enable / serial in
//   ccff_tail                   - last shadow bit (serial out)
//   cfg_commit, cfg_parity      - commit request, expected shadow parity
//   cfg_full, cfg_valid, cfg_err- chain full, config valid, sticky reject
// Optional build macro: CB_CFG_PARITY_EN adds a shadow parity check on commit;
// without it cfg_parity is ignored.
module cbx_param_dbuf
  import cb_pkg::*;
#(
  parameter int CHAN_W       = 9,
  parameter int NUM_IPIN     = 4,
  parameter int MUX_SIZE     = 6,
  parameter int TRACK_STRIDE = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  input  logic                cfg_commit,
  input  logic                cfg_parity,
  output logic                cfg_full,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int SEL_W   = cb_clog2(MUX_SIZE);
  localparam int CFG_LEN = NUM_IPIN * SEL_W;
  localparam int CNT_W   = cb_clog2(CFG_LEN + 1);

  if (!cb_mux_size_ok(MUX_SIZE, CHAN_W)) begin : g_bad_mux_size
    $error("cbx_param_dbuf: MUX_SIZE must be even and within 2..2*CHAN_W");
  end
  if (!cb_sel_w_ok(SEL_W)) begin : g_bad_sel_w
    $error("cbx_param_dbuf: SEL_W must be at least 1");
  end

  // Ascending ranges so index 0 is the first chain stage and, within each
  // pin field, the lowest index is the select MSB.
  logic [0:CFG_LEN-1] r_sh;
  logic [0:CFG_LEN-1] r_act;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_err;

  logic w_full;
  logic w_par_ok;
  logic w_accept;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  assign w_full = (r_cnt == CNT_W'(CFG_LEN));

`ifdef CB_CFG_PARITY_EN
  assign w_par_ok = ((^r_sh) == cfg_parity);
`else
  logic w_unused_parity;
  assign w_unused_parity = cfg_parity;
  assign w_par_ok        = 1'b1;
`endif

  assign w_accept = cfg_commit && w_full && w_par_ok;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_sh    <= '0;
      r_act   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (ccff_en) begin
        r_sh <= {ccff_head, r_sh[0:CFG_LEN-2]};
      end
      // Commit samples the pre-edge shadow; a coincident shift counts as
      // the first shift of the next load.
      if (w_accept) begin
        r_act   <= r_sh;
        r_valid <= 1'b1;
        r_cnt   <= ccff_en ? CNT_W'(1) : '0;
      end else if (ccff_en && !w_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (cfg_commit && !w_accept) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ccff_tail = r_sh[CFG_LEN-1];
  assign cfg_full  = w_full;
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [MUX_SIZE-1:0] w_mux_in;
    logic [SEL_W-1:0]    w_sel;

    for (genvar k = 0; k < MUX_SIZE / 2; k++) begin : g_pair
      localparam int T = cb_track_idx(i, k, TRACK_STRIDE, CHAN_W);
      assign w_mux_in[2*k]   = chanx_left_in[T];
      assign w_mux_in[2*k+1] = chanx_right_in[T];
    end

    assign w_sel = r_act[i*SEL_W +: SEL_W];

    cb_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .i_in  (w_mux_in),
      .i_sel (w_sel),
      .i_en  (r_valid),
      .o_out (ipin_out[i])
    );
  end

endmodule

// File: tb/tb_cbx_param_dbuf.sv
module tb_cbx_param_dbuf;

  localparam int CHAN_W       = 9;
  localparam int NUM_IPIN     = 4;
  localparam int MUX_SIZE     = 6;
  localparam int TRACK_STRIDE = 4;
  localparam int SEL_W        = 3;
  localparam int CFG_LEN      = NUM_IPIN * SEL_W;

  logic                prog_clk = 1'b0;
  logic                prog_reset = 1'b1;
  logic [CHAN_W-1:0]   chanx_left_in = '0;
  logic [CHAN_W-1:0]   chanx_right_in = '0;
  logic [CHAN_W-1:0]   chanx_left_out;
  logic [CHAN_W-1:0]   chanx_right_out;
  logic [NUM_IPIN-1:0] ipin_out;
  logic                ccff_en = 1'b0;
  logic                ccff_head = 1'b0;
  logic                ccff_tail;
  logic                cfg_commit = 1'b0;
  logic                cfg_parity = 1'b0;
  logic                cfg_full;
  logic                cfg_valid;
  logic                cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 prog_clk = ~prog_clk;

  cbx_param_dbuf #(
    .CHAN_W       (CHAN_W),
    .NUM_IPIN     (NUM_IPIN),
    .MUX_SIZE     (MUX_SIZE),
    .TRACK_STRIDE (TRACK_STRIDE)
  ) dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .ccff_en         (ccff_en),
    .ccff_head       (ccff_head),
    .ccff_tail       (ccff_tail),
    .cfg_commit      (cfg_commit),
    .cfg_parity      (cfg_parity),
    .cfg_full        (cfg_full),
    .cfg_valid       (cfg_valid),
    .cfg_err         (cfg_err)
  );

  // Reference model: m_hist[0] is the most recently shifted bit; positions
  // beyond the queue length read as 0. m_sel holds committed select values.
  bit m_hist[$];
  int m_sel[NUM_IPIN];
  int m_shifts;
  bit m_valid;
  bit m_err;

  function automatic bit hist_bit(input int j);
    return (j < m_hist.size()) ? m_hist[j] : 1'b0;
  endfunction

  function automatic bit m_par();
    int ones = 0;
    foreach (m_hist[j]) ones += m_hist[j];
    return bit'(ones % 2);
  endfunction

  function automatic bit m_full();
    return m_shifts == CFG_LEN;
  endfunction

  function automatic bit m_tail();
    return hist_bit(CFG_LEN - 1);
  endfunction

  function automatic logic [NUM_IPIN-1:0] exp_ipin(input logic [CHAN_W-1:0] l,
                                                   input logic [CHAN_W-1:0] r);
    logic [NUM_IPIN-1:0] e;
    int s, t;
    e = '0;
    if (m_valid) begin
      for (int i = 0; i < NUM_IPIN; i++) begin
        s = m_sel[i];
        if (s < MUX_SIZE) begin
          t = (i + (s / 2) * TRACK_STRIDE) % CHAN_W;
          e[i] = (s % 2 == 1) ? r[t] : l[t];
        end
      end
    end
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit head,
                            input bit commit, input bit par);
    bit ok;
    if (rst) begin
      m_hist.delete();
      foreach (m_sel[i]) m_sel[i] = 0;
      m_shifts = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
    end else begin
      ok = commit && m_full();
`ifdef CB_CFG_PARITY_EN
      ok = ok && (m_par() == par);
`endif
      if (commit && !ok) m_err = 1'b1;
      if (ok) begin
        for (int i = 0; i < NUM_IPIN; i++) begin
          m_sel[i] = 0;
          for (int b = 0; b < SEL_W; b++)
            m_sel[i] += int'(hist_bit(i * SEL_W + b)) << (SEL_W - 1 - b);
        end
        m_valid  = 1'b1;
        m_shifts = 0;
      end
      if (en) begin
        m_hist.push_front(head);
        if (m_hist.size() > CFG_LEN) void'(m_hist.pop_back());
        if (m_shifts < CFG_LEN) m_shifts++;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit head,
                       input bit commit, input bit par);
    prog_reset = rst;
    ccff_en    = en;
    ccff_head  = head;
    cfg_commit = commit;
    cfg_parity = par;
    @(posedge prog_clk);
    model_step(rst, en, head, commit, par);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic load_cfg(input logic [0:CFG_LEN-1] v);
    for (int n = 0; n < CFG_LEN; n++) cycle(1'b0, 1'b1, v[CFG_LEN-1-n], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    chanx_left_in  = 9'h1A5;
    chanx_right_in = 9'h05A;
    #1;
    n_tests++; if (chanx_right_out !== 9'h1A5) begin n_fail++;
      $display("FAIL reset_right_out: got %h want 1a5", chanx_right_out); end
    n_tests++; if (chanx_left_out !== 9'h05A) begin n_fail++;
      $display("FAIL reset_left_out: got %h want 05a", chanx_left_out); end
    n_tests++; if (ipin_out !== 4'b0) begin n_fail++;
      $display("FAIL reset_ipin: got %b want 0000", ipin_out); end
    n_tests++; if ({cfg_valid, cfg_full, cfg_err, ccff_tail} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: valid/full/err/tail got %b want 0000",
               {cfg_valid, cfg_full, cfg_err, ccff_tail}); end
  endtask

  task automatic test_route();
    logic [0:CFG_LEN-1] v;
    logic [CHAN_W-1:0] l, r;
    logic [NUM_IPIN-1:0] want;
    v = {3'd0, 3'd1, 3'd4, 3'd5};
    load_cfg(v);
    n_tests++; if (cfg_full !== 1'b1) begin n_fail++;
      $display("FAIL route_full: got %b want 1", cfg_full); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, m_par());
    n_tests++; if (cfg_valid !== 1'b1 || cfg_full !== 1'b0) begin n_fail++;
      $display("FAIL route_commit: valid=%b full=%b want 1 0", cfg_valid, cfg_full); end
    // Single-source toggles: each bit should reach exactly its pin.
    for (int n = 0; n < 6; n++) begin
      l = '0; r = '0;
      case (n)
        1: l = 9'b000000001;
        2: r = 9'b000000010;
        3: l = 9'b000000010;
        4: r = 9'b000000100;
        5: begin l = 9'h1FF; r = 9'h1FF; end
        default: ;
      endcase
      chanx_left_in = l; chanx_right_in = r;
      #1;
      want = {r[2], l[1], r[1], l[0]};
      n_tests++; if (ipin_out !== want) begin n_fail++;
        $display("FAIL route_toggle%0d: ipin got %b want %b", n, ipin_out, want); end
    end
    for (int n = 0; n < 6; n++) begin
      l = CHAN_W'($urandom); r = CHAN_W'($urandom);
      chanx_left_in = l; chanx_right_in = r;
      #1;
      want = {r[2], l[1], r[1], l[0]};
      n_tests++; if (ipin_out !== want) begin n_fail++;
        $display("FAIL route_rand: ipin got %b want %b", ipin_out, want); end
    end
  endtask

  task automatic test_reject();
    logic [NUM_IPIN-1:0] want;
    for (int n = 0; n < CFG_LEN - 1; n++) cycle(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, m_par());
    chanx_left_in = CHAN_W'($urandom); chanx_right_in = CHAN_W'($urandom);
    #1;
    want = exp_ipin(chanx_left_in, chanx_right_in);
    n_tests++; if (cfg_err !== 1'b1 || cfg_full !== 1'b0) begin n_fail++;
      $display("FAIL reject_flags: err=%b full=%b want 1 0", cfg_err, cfg_full); end
    n_tests++; if (ipin_out !== want) begin n_fail++;
      $display("FAIL reject_ipin: got %b want %b", ipin_out, want); end
    cycle(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    n_tests++; if (cfg_full !== 1'b1) begin n_fail++;
      $display("FAIL reject_12th_full: got %b want 1", cfg_full); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, m_par());
    #1;
    want = exp_ipin(chanx_left_in, chanx_right_in);
    n_tests++; if (cfg_err !== 1'b1 || cfg_valid !== 1'b1 || cfg_full !== 1'b0) begin n_fail++;
      $display("FAIL reject_then_accept: err=%b valid=%b full=%b want 1 1 0",
               cfg_err, cfg_valid, cfg_full); end
    n_tests++; if (ipin_out !== want) begin n_fail++;
      $display("FAIL reject_accept_ipin: got %b want %b", ipin_out, want); end
  endtask

  task automatic test_sel_invalid();
    logic [0:CFG_LEN-1] v;
    logic [NUM_IPIN-1:0] want;
    v = {3'd2, 3'd7, 3'd3, 3'd6};
    load_cfg(v);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, m_par());
    for (int n = 0; n < 8; n++) begin
      chanx_left_in  = (n == 0) ? 9'h1FF : CHAN_W'($urandom);
      chanx_right_in = (n == 0) ? 9'h1FF : CHAN_W'($urandom);
      #1;
      want = exp_ipin(chanx_left_in, chanx_right_in);
      n_tests++; if (ipin_out[1] !== 1'b0) begin n_fail++;
        $display("FAIL sel7_pin1: got %b want 0", ipin_out[1]); end
      n_tests++; if (ipin_out !== want) begin n_fail++;
        $display("FAIL sel_invalid_ipin: got %b want %b", ipin_out, want); end
    end
  endtask

  task automatic test_tail_latency();
    int gaps[2] = '{0, 5};
    int en_cnt;
    bit want;
    foreach (gaps[g]) begin
      do_reset();
      en_cnt = 0;
      for (int c = 0; c < CFG_LEN + gaps[g] + 2; c++) begin
        if (c >= 4 && c < 4 + gaps[g]) begin
          cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          cycle(1'b0, 1'b1, (en_cnt == 0), 1'b0, 1'b0);
          en_cnt++;
        end
        want = (en_cnt == CFG_LEN);
        n_tests++; if (ccff_tail !== want) begin n_fail++;
          $display("FAIL tail_gap%0d_cyc%0d: got %b want %b", gaps[g], c, ccff_tail, want); end
      end
    end
  endtask

  task automatic test_commit_shift_same();
    logic [0:CFG_LEN-1] v;
    logic [NUM_IPIN-1:0] want;
    int s_exp;
    v = CFG_LEN'($urandom);
    load_cfg(v);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, m_par());
    chanx_left_in = CHAN_W'($urandom); chanx_right_in = CHAN_W'($urandom);
    #1;
    want = exp_ipin(chanx_left_in, chanx_right_in);
    n_tests++; if (cfg_valid !== 1'b1 || cfg_full !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle_flags: valid=%b full=%b want 1 0", cfg_valid, cfg_full); end
    n_tests++; if (ipin_out !== want) begin n_fail++;
      $display("FAIL same_cycle_ipin: got %b want %b", ipin_out, want); end
    // Old shadow must be what landed in ACT: pin0 select is v[0:2].
    s_exp = int'(v[0:2]);
    n_tests++; if (m_sel[0] !== s_exp) begin n_fail++;
      $display("FAIL same_cycle_model_sel0: got %0d want %0d", m_sel[0], s_exp); end
    for (int n = 0; n < CFG_LEN - 2; n++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (cfg_full !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle_cnt_pre: full got %b want 0", cfg_full); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (cfg_full !== 1'b1) begin n_fail++;
      $display("FAIL same_cycle_cnt1: full got %b want 1", cfg_full); end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 5; n++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, m_par());
    #1;
    n_tests++; if ({cfg_valid, cfg_full, cfg_err, ccff_tail} !== 4'b0 || ipin_out !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flags: valid/full/err/tail=%b ipin=%b want 0000 0000",
               {cfg_valid, cfg_full, cfg_err, ccff_tail}, ipin_out); end
    for (int n = 0; n < CFG_LEN; n++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++; if (ccff_tail !== 1'b0) begin n_fail++;
        $display("FAIL reset_mid_sh_clear%0d: tail got %b want 0", n, ccff_tail); end
    end
  endtask

`ifdef CB_CFG_PARITY_EN
  task automatic test_parity();
    do_reset();
    load_cfg(CFG_LEN'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, ~m_par());
    n_tests++; if (cfg_err !== 1'b1 || cfg_valid !== 1'b0 || cfg_full !== 1'b1) begin n_fail++;
      $display("FAIL parity_reject: err=%b valid=%b full=%b want 1 0 1",
               cfg_err, cfg_valid, cfg_full); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, m_par());
    n_tests++; if (cfg_valid !== 1'b1) begin n_fail++;
      $display("FAIL parity_accept: valid got %b want 1", cfg_valid); end
  endtask
`endif

  task automatic test_random();
    logic [NUM_IPIN-1:0] want;
    bit rst, en, commit, par;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 59) == 0);
      en     = ($urandom_range(0, 3) != 0);
      commit = ($urandom_range(0, 6) == 0);
      par    = ($urandom_range(0, 4) == 0) ? ~m_par() : m_par();
      cycle(rst, en, 1'($urandom), commit, par);
      chanx_left_in = CHAN_W'($urandom); chanx_right_in = CHAN_W'($urandom);
      #1;
      want = exp_ipin(chanx_left_in, chanx_right_in);
      n_tests++; if (ipin_out !== want) begin n_fail++;
        $display("FAIL rand_ipin c%0d: got %b want %b", c, ipin_out, want); end
      n_tests++; if ({cfg_full, cfg_valid, cfg_err, ccff_tail} !==
                     {m_full(), m_valid, m_err, m_tail()}) begin n_fail++;
        $display("FAIL rand_flags c%0d: full/valid/err/tail got %b want %b", c,
                 {cfg_full, cfg_valid, cfg_err, ccff_tail},
                 {m_full(), m_valid, m_err, m_tail()}); end
      n_tests++; if (chanx_left_out !== chanx_right_in || chanx_right_out !== chanx_left_in) begin
        n_fail++;
        $display("FAIL rand_pass c%0d: left_out=%h right_out=%h want %h %h", c,
                 chanx_left_out, chanx_right_out, chanx_right_in, chanx_left_in); end
    end
  endtask

  initial begin
    @(negedge prog_clk);
    test_reset();
    test_route();
    test_reject();
    test_sel_invalid();
    test_tail_latency();
    do_reset();
    test_commit_shift_same();
    test_reset_mid();
`ifdef CB_CFG_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
